// File: rtl/beam_power_if.sv
// Sample/result handshake bundle for beam_power_integrator.
// The master drives beam samples and consumes results; the slave is the integrator.
interface beam_power_if #(
    parameter int Y_WORD_LENGTH = 24,
    parameter int ACC_WIDTH     = 32
);
    logic signed [Y_WORD_LENGTH-1:0] I_y;
    logic signed [Y_WORD_LENGTH-1:0] Q_y;
    logic                            in_valid;
    logic                            in_ready;
    logic [3:0]                      n_log2;
    logic [ACC_WIDTH-1:0]            power;
    logic                            out_valid;
    logic                            out_ready;
    logic                            overflow;

    modport master (
        output I_y, Q_y, in_valid, n_log2, out_ready,
        input  in_ready, power, out_valid, overflow
    );

    modport slave (
        input  I_y, Q_y, in_valid, n_log2, out_ready,
        output in_ready, power, out_valid, overflow
    );
endinterface

// File: rtl/beam_power_integrator.sv
// Block integrator of beam power sum(I^2+Q^2) over 2^n_log2 samples, 3-stage pipeline.
// Define BEAM_POW_SAT_EN to saturate the accumulator instead of wrapping on overflow.
module beam_power_integrator #(
    parameter int Y_WORD_LENGTH = 24,
    parameter int SHIFT         = 12,
    parameter int ACC_WIDTH     = 32,
    parameter int MAX_LOG2_N    = 10
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    beam_power_if.slave bus
);

    localparam int         W     = Y_WORD_LENGTH - SHIFT;
    localparam int         PW    = 2 * W;
    localparam int         CNT_W = MAX_LOG2_N + 1;
    localparam logic [3:0] MAX_N = 4'(MAX_LOG2_N);

    typedef enum logic [1:0] {IDLE, ACC, DRAIN, HOLD} state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_inc_d;
    logic [CNT_W-1:0]       target_d;
    logic [3:0]             n_q;
    logic [3:0]             n_clamp_d;
    logic signed [W-1:0]    s1_i_q, s1_q_q;
    logic signed [W-1:0]    s1_i_d, s1_q_d;
    logic                   s1_v_q, s1_last_q;
    logic                   s2_v_q, s2_last_q;
    logic                   s3_last_q;
    logic signed [PW-1:0]   i_sq_d, q_sq_d;
    logic [PW-1:0]          s2_pow_q, s2_pow_d;
    logic [ACC_WIDTH:0]     acc_sum_d;
    logic [ACC_WIDTH-1:0]   acc_q;
    logic                   acc_ovf_q;
    logic [ACC_WIDTH-1:0]   power_q;
    logic                   overflow_q;
    logic                   in_ready_q;
    logic                   out_valid_q;
    logic                   accept_d;
    logic                   last_d;

    assign accept_d  = bus.in_valid && in_ready_q;
    assign n_clamp_d = (bus.n_log2 > MAX_N) ? MAX_N : bus.n_log2;
    assign cnt_inc_d = cnt_q + CNT_W'(1);
    assign target_d  = CNT_W'(1) << n_q;
    // In IDLE the block length is not latched yet, so the live clamped value decides.
    assign last_d    = (state_q == IDLE) ? (n_clamp_d == 4'd0) : (cnt_inc_d == target_d);

    assign s1_i_d    = W'(bus.I_y >>> SHIFT);
    assign s1_q_d    = W'(bus.Q_y >>> SHIFT);
    assign i_sq_d    = PW'(s1_i_q) * PW'(s1_i_q);
    assign q_sq_d    = PW'(s1_q_q) * PW'(s1_q_q);
    assign s2_pow_d  = i_sq_d + q_sq_d;
    assign acc_sum_d = {1'b0, acc_q} + (ACC_WIDTH + 1)'(s2_pow_q);

    // NOTE: every register here is written with <= so all stages sample pre-edge values
    // and the pipeline shifts by exactly one stage per clock regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            n_q         <= '0;
            s1_i_q      <= '0;
            s1_q_q      <= '0;
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_pow_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_last_q   <= 1'b0;
            s3_last_q   <= 1'b0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            power_q     <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
        end else if (clear) begin
            // NOTE: data registers are zeroed too, not just their valid bits, so a flushed
            // pipeline never carries stale samples into the next block.
            state_q     <= IDLE;
            cnt_q       <= '0;
            s1_i_q      <= '0;
            s1_q_q      <= '0;
            s1_v_q      <= 1'b0;
            s1_last_q   <= 1'b0;
            s2_pow_q    <= '0;
            s2_v_q      <= 1'b0;
            s2_last_q   <= 1'b0;
            s3_last_q   <= 1'b0;
            acc_q       <= '0;
            acc_ovf_q   <= 1'b0;
            power_q     <= '0;
            overflow_q  <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            s1_v_q    <= accept_d;
            s1_last_q <= accept_d && last_d;
            if (accept_d) begin
                s1_i_q <= s1_i_d;
                s1_q_q <= s1_q_d;
            end
            s2_v_q    <= s1_v_q;
            s2_last_q <= s1_v_q && s1_last_q;
            if (s1_v_q) s2_pow_q <= s2_pow_d;
            s3_last_q <= s2_v_q && s2_last_q;

            if (s2_v_q) begin
`ifdef BEAM_POW_SAT_EN
                if (acc_sum_d[ACC_WIDTH]) begin
                    acc_q     <= '1;
                    acc_ovf_q <= 1'b1;
                end else begin
                    acc_q <= acc_sum_d[ACC_WIDTH-1:0];
                end
`else
                acc_q <= acc_sum_d[ACC_WIDTH-1:0];
                if (acc_sum_d[ACC_WIDTH]) acc_ovf_q <= 1'b1;
`endif
            end

            in_ready_q <= (state_q == IDLE) || (state_q == ACC);

            case (state_q)
                IDLE: begin
                    if (accept_d) begin
                        n_q   <= n_clamp_d;
                        cnt_q <= CNT_W'(1);
                        if (last_d) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q <= ACC;
                        end
                    end
                end
                ACC: begin
                    if (accept_d) begin
                        cnt_q <= cnt_inc_d;
                        if (last_d) begin
                            state_q    <= DRAIN;
                            in_ready_q <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    if (s3_last_q) begin
                        power_q     <= acc_q;
                        overflow_q  <= acc_ovf_q;
                        out_valid_q <= 1'b1;
                        state_q     <= HOLD;
                    end
                end
                HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        acc_q       <= '0;
                        acc_ovf_q   <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= IDLE;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.power     = power_q;
    assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_beam_power_integrator.sv
// Directed bench for beam_power_integrator: block vectors from a table plus
// hand-written sequences for hold, clear, gaps and mid-block reset.
module tb_beam_power_integrator;

    logic clk = 1'b0;
    logic rst_n;
    logic clear;
    int   n_cmp  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    beam_power_if #(.Y_WORD_LENGTH(24), .ACC_WIDTH(32)) bus ();

    beam_power_integrator dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .bus   (bus)
    );

    typedef struct {
        logic signed [23:0] i;
        logic signed [23:0] q;
        logic [3:0]         n;
        int                 count;
        logic [31:0]        pwr;
        logic               ovf;
    } vec_t;

    localparam int NV = 7;
    vec_t vec [NV];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int c = 0;
        while (bus.in_ready !== 1'b1 && c < 64) begin
            tick();
            c++;
        end
        if (c == 64) check("in_ready_wait", {63'd0, bus.in_ready}, 64'd1);
    endtask

    // One sample accepted on the next edge; consecutive calls stay back-to-back.
    task automatic send(input logic signed [23:0] i, input logic signed [23:0] q);
        wait_ready();
        bus.I_y      = i;
        bus.Q_y      = q;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    // Called right after the last acceptance edge; expects out_valid on the 3rd edge.
    task automatic wait_result(input string name, input logic [31:0] pwr, input logic ovf);
        check({name, "_drain_ready"}, {63'd0, bus.in_ready}, 64'd0);
        tick();
        tick();
        check({name, "_early_valid"}, {63'd0, bus.out_valid}, 64'd0);
        tick();
        check({name, "_valid_lat3"}, {63'd0, bus.out_valid}, 64'd1);
        check({name, "_power"}, {32'd0, bus.power}, {32'd0, pwr});
        check({name, "_overflow"}, {63'd0, bus.overflow}, {63'd0, ovf});
    endtask

    task automatic take_result(input string name);
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        check({name, "_valid_drop"}, {63'd0, bus.out_valid}, 64'd0);
        check({name, "_ready_back"}, {63'd0, bus.in_ready}, 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;

        vec[0] = '{i: 24'sd4096,    q: 24'sd8192,    n: 4'd2,  count: 4,    pwr: 32'd20,       ovf: 1'b0};
        vec[1] = '{i: -24'sd1,      q: 24'sd0,       n: 4'd0,  count: 1,    pwr: 32'd1,        ovf: 1'b0};
        vec[2] = '{i: -24'sd4097,   q: 24'sd4095,    n: 4'd3,  count: 8,    pwr: 32'd32,       ovf: 1'b0};
        vec[3] = '{i: 24'sd8388607, q: -24'sd8388608, n: 4'd1, count: 2,    pwr: 32'd16769026, ovf: 1'b0};
        vec[4] = '{i: 24'sd4096,    q: 24'sd0,       n: 4'd15, count: 1024, pwr: 32'd1024,     ovf: 1'b0};
`ifdef BEAM_POW_SAT_EN
        vec[5] = '{i: -24'sd8388608, q: -24'sd8388608, n: 4'd10, count: 1024, pwr: 32'hFFFF_FFFF, ovf: 1'b1};
        vec[6] = '{i: 24'sd8388607,  q: 24'sd8388607,  n: 4'd10, count: 1024, pwr: 32'hFFFF_FFFF, ovf: 1'b1};
`else
        vec[5] = '{i: -24'sd8388608, q: -24'sd8388608, n: 4'd10, count: 1024, pwr: 32'h0000_0000, ovf: 1'b1};
        vec[6] = '{i: 24'sd8388607,  q: 24'sd8388607,  n: 4'd10, count: 1024, pwr: 32'hFF80_0800, ovf: 1'b1};
`endif

        rst_n         = 1'b0;
        clear         = 1'b0;
        bus.I_y       = '0;
        bus.Q_y       = '0;
        bus.in_valid  = 1'b0;
        bus.n_log2    = '0;
        bus.out_ready = 1'b0;

        // Reset values, and in_ready rising only on the first edge after release.
        #1;
        check("rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_power",     {32'd0, bus.power},     64'd0);
        check("rst_overflow",  {63'd0, bus.overflow},  64'd0);
        #21;
        rst_n = 1'b1;
        #1;
        check("rel_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
        tick();
        check("rel_in_ready_high", {63'd0, bus.in_ready}, 64'd1);

        for (int v = 0; v < NV; v++) begin
            bus.n_log2 = vec[v].n;
            for (int k = 0; k < vec[v].count; k++) send(vec[v].i, vec[v].q);
            wait_result($sformatf("v%0d", v), vec[v].pwr, vec[v].ovf);
            take_result($sformatf("v%0d", v));
        end

        // Gaps and an n_log2 change inside the block, then a 5-cycle stall on out_ready.
        bus.n_log2 = 4'd2;
        send(24'sd4096, 24'sd8192);
        bus.n_log2 = 4'd0;
        tick();
        tick();
        send(24'sd4096, 24'sd8192);
        tick();
        send(24'sd4096, 24'sd8192);
        send(24'sd4096, 24'sd8192);
        wait_result("hold", 32'd20, 1'b0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("hold%0d_valid", c), {63'd0, bus.out_valid}, 64'd1);
            check($sformatf("hold%0d_power", c), {32'd0, bus.power}, 64'd20);
            check($sformatf("hold%0d_ready", c), {63'd0, bus.in_ready}, 64'd0);
        end
        take_result("hold");

        // Clear after 2 of 4 samples (with a competing in_valid), then a fresh block.
        seen = 1'b0;
        bus.n_log2 = 4'd2;
        send(24'sd4096, 24'sd8192);
        send(24'sd4096, 24'sd8192);
        clear        = 1'b1;
        bus.in_valid = 1'b1;
        tick();
        clear        = 1'b0;
        bus.in_valid = 1'b0;
        check("clr_in_ready",  {63'd0, bus.in_ready},  64'd1);
        check("clr_out_valid", {63'd0, bus.out_valid}, 64'd0);
        for (int k = 0; k < 3; k++) begin
            send(24'sd4096, 24'sd0);
            seen = seen | bus.out_valid;
        end
        send(24'sd4096, 24'sd0);
        check("clr_no_early_result", {63'd0, seen}, 64'd0);
        wait_result("clr", 32'd4, 1'b0);
        take_result("clr");

        // Reset pulse while the block drains: outputs drop at once, no result follows.
        bus.n_log2 = 4'd2;
        for (int k = 0; k < 4; k++) send(24'sd8192, 24'sd8192);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  {63'd0, bus.in_ready},  64'd0);
        check("mid_rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("mid_rst_power",     {32'd0, bus.power},     64'd0);
        check("mid_rst_overflow",  {63'd0, bus.overflow},  64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            tick();
            seen = seen | bus.out_valid;
        end
        check("post_rst_no_result", {63'd0, seen}, 64'd0);
        bus.n_log2 = 4'd1;
        send(24'sd4096, 24'sd4096);
        send(24'sd4096, 24'sd4096);
        wait_result("post_rst", 32'd4, 1'b0);
        take_result("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/beam_power_integrator.md
BEAM_POWER_INTEGRATOR -- requirements
Module: beam_power_integrator

Interface
REQ-001 SHALL have parameter Y_WORD_LENGTH, default 24, width of the signed beamformer output samples.
REQ-002 SHALL have parameter SHIFT, default 12, arithmetic right-shift applied to each input component before squaring.
REQ-003 SHALL have parameter ACC_WIDTH, default 32, width of the unsigned power accumulator and result.
REQ-004 SHALL have parameter MAX_LOG2_N, default 10, largest supported log2 of the integration length.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1 rising-edge clock; rst_n input 1 reset.
REQ-006 SHALL have clear, input, 1 bit: synchronous abort of the current block.
REQ-007 SHALL have I_y and Q_y, input, Y_WORD_LENGTH bits each, signed: the beam sample, real and imaginary.
REQ-008 SHALL have in_valid (input, 1) and in_ready (output, 1) as the sample handshake.
REQ-009 SHALL have n_log2, input, 4 bits: integration length is 2^n_log2 samples.
REQ-010 SHALL have power, output, ACC_WIDTH bits, unsigned: the block sum of I^2+Q^2.
REQ-011 SHALL have out_valid (output, 1) and out_ready (input, 1) as the result handshake.
REQ-012 SHALL have overflow, output, 1 bit: the accumulator exceeded 2^ACC_WIDTH-1 in the reported block.

Function
REQ-013 Sample accepted SHALL mean in_valid && in_ready on a rising clk edge.
REQ-014 Each component SHALL be arithmetic-shifted right by SHIFT (floor, no rounding), giving W = Y_WORD_LENGTH-SHIFT bits signed.
REQ-015 Pipeline SHALL be: S1 registers shifted I,Q; S2 registers I^2+Q^2 (2W bits unsigned, exact); S3 adds it into the accumulator.
REQ-016 FSM states SHALL be IDLE, ACC, DRAIN, HOLD; in_ready = 1 in IDLE and ACC only.
REQ-017 IDLE: first accepted sample latches n_log2, clamped to MAX_LOG2_N, loads the sample counter to 1, and enters ACC (or DRAIN if the length is 1).
REQ-018 ACC: each accepted sample increments the counter; the sample that reaches 2^n_log2 moves the FSM to DRAIN.
REQ-019 DRAIN: in_ready=0 until the last sample leaves S3, then power and overflow are registered, out_valid=1, and the FSM enters HOLD.
REQ-020 Latency SHALL be exactly 3 clk cycles from acceptance of the last sample to out_valid=1.
REQ-021 HOLD: power, overflow and out_valid SHALL stay stable while out_ready=0; on out_valid && out_ready, out_valid=0 and the accumulator and flag clear in the same cycle and the FSM returns to IDLE.
REQ-022 Gaps (in_valid=0) in ACC SHALL not advance the counter or the pipeline contents' block membership.
REQ-023 clear=1 SHALL, in any state, flush S1-S3, zero the accumulator, counter and overflow, force out_valid=0, and go to IDLE next cycle; clear has priority over every handshake in the same cycle.
REQ-024 n_log2 changes outside IDLE SHALL be ignored until the next block.

Reset
REQ-025 While rst_n=0: state=IDLE, in_ready=0, out_valid=0, power=0, overflow=0, pipeline and counter zero.
REQ-026 in_ready SHALL rise on the first clk edge after rst_n deasserts; a reset mid-block discards the block with no result.

Configuration
REQ-027 With BEAM_POW_SAT_EN defined, accumulator overflow SHALL saturate at 2^ACC_WIDTH-1 and set overflow.
REQ-028 Without BEAM_POW_SAT_EN, the accumulator SHALL wrap modulo 2^ACC_WIDTH and overflow SHALL still be set on any carry out.

Verification (defaults)
REQ-029 I_y=4096, Q_y=8192, n_log2=2, 4 back-to-back samples -> power=20, overflow=0, out_valid exactly 3 cycles after the 4th acceptance.
REQ-030 I_y=-1, Q_y=0, n_log2=0, one sample -> shifted I=-1, power=1, FSM goes IDLE->DRAIN->HOLD.
REQ-031 I_y=Q_y=-8388608, n_log2=10, 1024 samples -> SAT: power=0xFFFFFFFF, overflow=1; no SAT: power=0x00000000, overflow=1.
REQ-032 Result pending with out_ready=0 for 5 cycles -> power and out_valid stable, in_ready=0; out_ready=1 -> next cycle out_valid=0, in_ready=1.
REQ-033 clear=1 after 2 of 4 samples, then 4 samples of I_y=4096, Q_y=0 -> power=4, with no earlier result emitted.
REQ-034 rst_n pulsed low mid-DRAIN -> all outputs 0 immediately, no out_valid afterwards until a new full block.
